serial_sub_ctrl: RTL and testbench

Sequencer that performs wide subtraction (A − B − bin) over NIBBLES×4 bits. It time-multiplexes one 4-bit ripple subtractor cell (`subtractor`: A, B, Bin → Bout, Diff), processing one nibble per clock from LSB to MSB. The borrow is registered between nibbles. The block sits between a requester that uses a start/busy/done handshake and the shared 4-bit borrow datapath.

---
 rtl/serial_sub_ctrl.sv | 164 ++++++++++++++++
 tb/tb_serial_sub_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_sub_ctrl
//
// Purpose:
//   Computes a wide subtraction (a - b - bin) over NIBBLES x 4 bits with a
//   single shared 4-bit ripple subtractor cell. One nibble is processed per
//   clock, from LSB to MSB. The borrow between nibbles is held in a register.
//   The requester side uses a start/busy/done handshake.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous, active-low reset
//   start  in   request; sampled only when busy=0 (IDLE or DONE)
//   a      in   W-bit minuend, captured on the accepted start
//   b      in   W-bit subtrahend, captured on the accepted start
//   bin    in   borrow into nibble 0, captured on the accepted start
//   busy   out  high while an operation is in progress
//   done   out  one-cycle pulse when diff/bout/zero are valid
//   diff   out  W-bit result register
//   bout   out  borrow out of the MSB nibble (1 = a < b + bin, unsigned)
//   zero   out  diff == 0 for the completed operation
//
// All outputs are registered. W = 4*NIBBLES.
// -----------------------------------------------------------------------------

// 4-bit ripple borrow subtractor cell: diff = a - b - bin, bout = final borrow.
module subtractor (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic       bout,
    output logic [3:0] diff
);
    logic [4:0] brw;

    assign brw[0] = bin;

    for (genvar gi = 0; gi < 4; gi++) begin : g_bit
        assign diff[gi]    = a[gi] ^ b[gi] ^ brw[gi];
        // Borrow out when a<b, or a==b and a borrow is coming in.
        assign brw[gi + 1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & brw[gi]);
    end

    assign bout = brw[4];
endmodule

module serial_sub_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   bin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   diff,
    output logic                   bout,
    output logic                   zero
);
    localparam int W     = 4 * NIBBLES;
    // Index counter is at least one bit wide so NIBBLES=1 still has a counter.
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic             brw_reg;
    logic [IDX_W-1:0] idx_reg;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       cell_diff;
    logic             cell_bout;
    logic [W-1:0]     diff_next;

    // Select the active operand nibbles. Compared against each legal index so
    // no out-of-range select is ever formed for non-power-of-two NIBBLES.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                a_nib = a_reg[i*4 +: 4];
                b_nib = b_reg[i*4 +: 4];
            end
        end
    end

    subtractor u_cell (
        .a    (a_nib),
        .b    (b_nib),
        .bin  (brw_reg),
        .bout (cell_bout),
        .diff (cell_diff)
    );

    // Result with the current nibble replaced; used both as the new diff and
    // to evaluate zero on the final edge from the complete value.
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_diff
        assign diff_next[gi*4 +: 4] = (idx_reg == IDX_W'(gi)) ? cell_diff
                                                                : diff[gi*4 +: 4];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            brw_reg   <= 1'b0;
            idx_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    // DONE accepts start exactly like IDLE for back-to-back use.
                    done <= 1'b0;
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        brw_reg   <= bin;
                        idx_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= RUN;
                    end else begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    diff    <= diff_next;
                    brw_reg <= cell_bout;
                    if (idx_reg == IDX_LAST) begin
                        idx_reg   <= '0;
                        bout      <= cell_bout;
                        zero      <= (diff_next == '0);
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_sub_ctrl
//
// Directed bench for serial_sub_ctrl: a NIBBLES=4 instance carries most of the
// vectors, a NIBBLES=1 instance covers the single-nibble build. Inputs change
// and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_serial_sub_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;

    // NIBBLES=4 instance
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        bout;
    logic        zero;

    // NIBBLES=1 instance
    logic        s1_start;
    logic [3:0]  s1_a;
    logic [3:0]  s1_b;
    logic        s1_bin;
    logic        s1_busy;
    logic        s1_done;
    logic [3:0]  s1_diff;
    logic        s1_bout;
    logic        s1_zero;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.NIBBLES(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .zero  (zero)
    );

    serial_sub_ctrl #(.NIBBLES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (s1_start),
        .a     (s1_a),
        .b     (s1_b),
        .bin   (s1_bin),
        .busy  (s1_busy),
        .done  (s1_done),
        .diff  (s1_diff),
        .bout  (s1_bout),
        .zero  (s1_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Issue one request on the 4-nibble instance, then check latency and result.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic bv_in, input logic [15:0] exp_diff,
                          input logic exp_bout, input logic exp_zero);
        int cycles;
        @(negedge clk);
        start = 1'b1; a = av; b = bv; bin = bv_in;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (busy && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, 64'(cycles), 64'd4);
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " diff"}, 64'(diff), 64'(exp_diff));
        check({tag, " bout"}, 64'(bout), 64'(exp_bout));
        check({tag, " zero"}, 64'(zero), 64'(exp_zero));
        @(negedge clk);
        check({tag, " done_drop"}, 64'(done), 64'd0);
    endtask

    initial begin
        int done_cnt;
        int cycles;
        rst_n = 1'b0;
        start = 1'b0; a = '0; b = '0; bin = 1'b0;
        s1_start = 1'b0; s1_a = '0; s1_b = '0; s1_bin = 1'b0;

        // Reset held two cycles, then released.
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst diff", 64'(diff), 64'h0);
        check("rst bout", 64'(bout), 64'd0);
        check("rst zero", 64'(zero), 64'd0);
        check("rst n1 busy", 64'(s1_busy), 64'd0);

        // Basic and boundary arithmetic.
        run_op("op1234", 16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0);
        run_op("under",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_op("binmsb", 16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b0);
        run_op("equal",  16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b1);

        // Start while busy is ignored.
        @(negedge clk);
        start = 1'b1; a = 16'h5555; b = 16'h1111; bin = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                done_cnt++;
                check("ignore diff", 64'(diff), 64'h4444);
            end
            @(negedge clk);
        end
        check("ignore done_count", 64'(done_cnt), 64'd1);
        check("ignore busy_idle", 64'(busy), 64'd0);

        // start held continuously: result every 5 cycles.
        start = 1'b1; a = 16'h0010; b = 16'h0001; bin = 1'b0;
        done_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                check("b2b done_phase", 64'(i % 5), 64'd0);
                check("b2b diff", 64'(diff), 64'h000F);
                check("b2b bout", 64'(bout), 64'd0);
            end
        end
        check("b2b done_count", 64'(done_cnt), 64'd4);
        start = 1'b0;
        cycles = 0;
        while ((busy || done) && cycles < 20) begin
            cycles++;
            @(negedge clk);
        end
        check("b2b drained", 64'(busy | done), 64'd0);

        // Reset in the middle of RUN aborts without a done pulse.
        start = 1'b1; a = 16'h1000; b = 16'h0001; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort diff", 64'(diff), 64'h0);
        check("abort bout", 64'(bout), 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        check("abort no_activity", 64'(done_cnt), 64'd0);
        run_op("after_abort", 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0);

        // Single-nibble build.
        @(negedge clk);
        s1_start = 1'b1; s1_a = 4'h3; s1_b = 4'h5; s1_bin = 1'b1;
        @(negedge clk);
        s1_start = 1'b0;
        cycles = 0;
        while (s1_busy && cycles < 10) begin
            cycles++;
            @(negedge clk);
        end
        check("n1 busy_cycles", 64'(cycles), 64'd1);
        check("n1 done", 64'(s1_done), 64'd1);
        check("n1 diff", 64'(s1_diff), 64'hD);
        check("n1 bout", 64'(s1_bout), 64'd1);
        check("n1 zero", 64'(s1_zero), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
